// File: rtl/pattern_hit_monitor.sv
// rtl/pattern_hit_monitor.sv - edge-qualified hit counter with sliding burst window and sticky alarm
module pattern_hit_monitor #(
    parameter int CNT_W      = 16,
    parameter int WIN_W      = 8,
    parameter int WINDOW     = 100,
    parameter int HIT_THRESH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hit_in,
    input  logic             enable,
    input  logic             clear,
    input  logic             alarm_ack,
    output logic [CNT_W-1:0] hit_count,
    output logic [WIN_W-1:0] win_hits,
    output logic             window_active,
    output logic             alarm,
    output logic             hit_seen
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        ALARM = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    // Timer holds (edges since first hit) - 1, so it reads WINDOW-2 on the last in-window edge.
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 2);
    localparam logic [WIN_W-1:0] THRESH   = WIN_W'(HIT_THRESH);

    state_t           state;
    logic             hit_d;
    logic [WIN_W-1:0] timer;
    logic             accepted;
    logic [WIN_W-1:0] win_next;

    assign accepted      = hit_in & ~hit_d & enable & ~clear;
    assign win_next      = win_hits + WIN_W'(1);
    assign window_active = (state == ARMED);
    assign alarm         = (state == ALARM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            hit_d     <= 1'b0;
            timer     <= '0;
            win_hits  <= '0;
            hit_count <= '0;
            hit_seen  <= 1'b0;
        end else begin
            hit_d <= hit_in;
            if (clear) begin
                state     <= IDLE;
                timer     <= '0;
                win_hits  <= '0;
                hit_count <= '0;
                hit_seen  <= 1'b0;
            end else begin
                hit_seen <= accepted;
                if (accepted && hit_count != CNT_MAX)
                    hit_count <= hit_count + CNT_W'(1);

                case (state)
                    IDLE: begin
                        timer    <= '0;
                        win_hits <= '0;
                        if (accepted) begin
                            win_hits <= WIN_W'(1);
                            state    <= (HIT_THRESH == 1) ? ALARM : ARMED;
                        end
                    end
                    ARMED: begin
                        // Threshold test wins over expiry on the same edge.
                        if (accepted && win_next == THRESH) begin
                            win_hits <= win_next;
                            state    <= ALARM;
                        end else if (timer == WIN_LAST) begin
                            timer    <= '0;
                            win_hits <= '0;
                            state    <= IDLE;
                        end else begin
                            timer <= timer + WIN_W'(1);
                            if (accepted)
                                win_hits <= win_next;
                        end
                    end
                    ALARM: begin
                        if (alarm_ack) begin
                            timer    <= '0;
                            win_hits <= '0;
                            state    <= IDLE;
                        end
                    end
                    default: begin
                        timer    <= '0;
                        win_hits <= '0;
                        state    <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pattern_hit_monitor.sv
// tb/tb_pattern_hit_monitor.sv - scoreboard bench for pattern_hit_monitor
module tb_pattern_hit_monitor;

    localparam int WINDOW = 100;
    localparam int THRESH = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic hit_in = 1'b0, enable = 1'b1, clear = 1'b0, alarm_ack = 1'b0;
    logic hs = 1'b0;
    logic one = 1'b1, zero = 1'b0;

    logic [15:0] hit_count;
    logic [7:0]  win_hits;
    logic        window_active, alarm, hit_seen;
    logic [3:0]  sat_count;
    logic [7:0]  sat_win;
    logic        sat_wa, sat_al, sat_seen;

    always #5 clk = ~clk;

    pattern_hit_monitor dut (
        .clk(clk), .reset(reset), .hit_in(hit_in), .enable(enable),
        .clear(clear), .alarm_ack(alarm_ack), .hit_count(hit_count),
        .win_hits(win_hits), .window_active(window_active), .alarm(alarm),
        .hit_seen(hit_seen)
    );

    pattern_hit_monitor #(.CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .hit_in(hs), .enable(one),
        .clear(zero), .alarm_ack(zero), .hit_count(sat_count),
        .win_hits(sat_win), .window_active(sat_wa), .alarm(sat_al),
        .hit_seen(sat_seen)
    );

    typedef struct packed {
        logic [15:0] cnt;
        logic [7:0]  win;
        logic        wa;
        logic        al;
        logic        seen;
        logic [3:0]  scnt;
    } exp_t;

    exp_t q[$];
    int n_vec = 0;
    int n_err = 0;

    // reference model: window tracked by absolute start edge rather than a timer
    int m_state, m_cnt, m_win, m_start, m_seen, s_cnt, cyc;
    bit m_hitd, s_hitd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_win = 0; m_start = 0; m_seen = 0;
        s_cnt = 0; cyc = 0; m_hitd = 1'b0; s_hitd = 1'b0;
    endtask

    task automatic step(input logic h, input logic e, input logic c, input logic a);
        exp_t x;
        bit acc, sacc;
        int age;
        hit_in = h; enable = e; clear = c; alarm_ack = a;
        acc = h && !m_hitd && e && !c;
        m_hitd = h;
        sacc = hs && !s_hitd;
        s_hitd = hs;
        if (sacc && s_cnt < 15) s_cnt++;
        if (c) begin
            m_state = 0; m_cnt = 0; m_win = 0; m_seen = 0;
        end else begin
            m_seen = acc ? 1 : 0;
            if (acc && m_cnt < 65535) m_cnt++;
            age = cyc - m_start;
            case (m_state)
                0: if (acc) begin
                    m_win = 1; m_start = cyc; m_state = (THRESH == 1) ? 2 : 1;
                end
                1: begin
                    if (acc) m_win++;
                    if (m_win == THRESH) m_state = 2;
                    else if (age >= WINDOW - 1) begin m_state = 0; m_win = 0; end
                end
                default: if (a) begin m_state = 0; m_win = 0; end
            endcase
        end
        cyc++;
        x.cnt  = 16'(m_cnt);
        x.win  = 8'(m_win);
        x.wa   = (m_state == 1);
        x.al   = (m_state == 2);
        x.seen = (m_seen != 0);
        x.scnt = 4'(s_cnt);
        q.push_back(x);
        @(posedge clk);
        #1;
        x = q.pop_front();
        check("hit_count", 32'(hit_count), 32'(x.cnt));
        check("win_hits", 32'(win_hits), 32'(x.win));
        check("window_active", 32'(window_active), 32'(x.wa));
        check("alarm", 32'(alarm), 32'(x.al));
        check("hit_seen", 32'(hit_seen), 32'(x.seen));
        check("sat_count", 32'(sat_count), 32'(x.scnt));
    endtask

    task automatic hits3(input int a, input int b, input int c);
        for (int e = 0; e <= c; e++)
            step((e == a) || (e == b) || (e == c), 1'b1, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cnt"}, 32'(hit_count), 0);
        check({tag, "_win"}, 32'(win_hits), 0);
        check({tag, "_wa"}, 32'(window_active), 0);
        check({tag, "_alarm"}, 32'(alarm), 0);
        check({tag, "_seen"}, 32'(hit_seen), 0);
    endtask

    initial begin
        int seen_n;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("rst");
        reset = 1'b0;

        // asynchronous reset mid-window
        step(1, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 0); step(1, 1, 0, 0); step(0, 1, 0, 0);
        check("pre_rst_win", 32'(win_hits), 2);
        #2 reset = 1'b1;
        #1 check_all_zero("async_rst");
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        step(1, 1, 0, 0);
        check("post_rst_win", 32'(win_hits), 1);
        check("post_rst_cnt", 32'(hit_count), 1);
        step(0, 1, 1, 0);

        // burst alarm, hit during alarm, acknowledge
        hits3(0, 3, 6);
        check("burst_alarm", 32'(alarm), 1);
        check("burst_cnt", 32'(hit_count), 3);
        check("burst_win", 32'(win_hits), 3);
        step(0, 1, 0, 0); step(0, 1, 0, 0); step(1, 1, 0, 0);
        check("alarm_hit_cnt", 32'(hit_count), 4);
        check("alarm_hold", 32'(alarm), 1);
        step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 1);
        check("ack_alarm", 32'(alarm), 0);
        check("ack_win", 32'(win_hits), 0);

        // window boundary: last in-window edge, then first out-of-window edge
        step(0, 1, 1, 0);
        hits3(0, 50, 99);
        check("edge99_alarm", 32'(alarm), 1);
        step(0, 1, 0, 1);
        step(0, 1, 1, 0);
        hits3(0, 50, 100);
        check("edge100_alarm", 32'(alarm), 0);
        check("edge100_wa", 32'(window_active), 1);
        check("edge100_win", 32'(win_hits), 1);
        step(0, 1, 1, 0);

        // level held high counts once
        seen_n = 0;
        for (int i = 0; i < 6; i++) begin
            step(i < 5, 1, 0, 0);
            seen_n += int'(hit_seen);
        end
        check("level_cnt", 32'(hit_count), 1);
        check("level_seen", 32'(seen_n), 1);
        step(1, 0, 0, 0); step(0, 0, 0, 0); step(1, 0, 0, 0); step(0, 0, 0, 0);
        check("disabled_cnt", 32'(hit_count), 1);
        // back-to-back pulses with one low cycle
        step(1, 1, 0, 0); step(0, 1, 0, 0); step(1, 1, 0, 0); step(0, 1, 0, 0);
        check("b2b_cnt", 32'(hit_count), 3);
        check("b2b_alarm", 32'(alarm), 1);

        // clear beats ack and hit in ALARM
        step(1, 1, 1, 1);
        check("prio_cnt", 32'(hit_count), 0);
        check("prio_alarm", 32'(alarm), 0);
        check("prio_seen", 32'(hit_seen), 0);
        step(0, 1, 0, 0);
        check("prio_seen_after", 32'(hit_seen), 0);

        // 4-bit saturation
        for (int i = 0; i < 20; i++) begin
            hs = 1'b1; step(0, 1, 0, 0);
            hs = 1'b0; step(0, 1, 0, 0); step(0, 1, 0, 0);
        end
        check("sat_cnt", 32'(sat_count), 15);
        repeat (3) step(0, 1, 0, 0);
        check("sat_hold", 32'(sat_count), 15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
